// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter slice.
//   state_t : sequencer states (IDLE -> EXEC -> RESP -> IDLE)
//   OP_*    : ALU op codes, carried unmodified from a requester to the ALU
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;  // y = a + b, cf = carry out
  localparam logic [2:0] OP_SUB  = 3'b001;  // y = a - b, cf = borrow
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;  // y = 1 when a < b (signed)
  localparam logic [2:0] OP_SLTU = 3'b110;  // y = 1 when a < b (unsigned)
  localparam logic [2:0] OP_NOR  = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between NREQ requesters and the shared ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (ready is one-hot)
//   req_a/req_b/req_m   : packed operands and op code, requester i owns slice i
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot)
//   rsp_y/zf/cf/of      : registered ALU result and flags
//   busy, grant_id      : sequencer status
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_m;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic                  rsp_zf;
  logic                  rsp_cf;
  logic                  rsp_of;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  modport master (
    output req_valid, req_a, req_b, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zf, rsp_cf, rsp_of, busy, grant_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zf, rsp_cf, rsp_of, busy, grant_id
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter.
//   a, b : operands (WIDTH bits)
//   m    : op code (OP_* in the package)
//   y    : result (WIDTH bits, no extension)
//   zf   : y == 0
//   cf   : carry out for add, borrow for sub, 0 otherwise
//   of   : signed overflow for add/sub, 0 otherwise
module alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       m,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             cf,
  output logic             of
);

  logic [WIDTH:0] wide;

  always_comb begin
    wide = '0;
    y    = '0;
    cf   = 1'b0;
    of   = 1'b0;
    case (m)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        of   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra MSB of a zero-extended subtraction is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        of   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: y = WIDTH'(a < b);
      default: y = ~(a | b);
    endcase
    zf = (y == '0);
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request bits
//   ptr   : index with highest priority this round
//   grant : one-hot winner (0 when no request)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Scan from the lowest priority upwards so the last hit, the one
    // closest to ptr, is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NREQ requesters.
// One operation at a time: IDLE (grant) -> EXEC (ALU runs on latched
// operands) -> RESP (result held until the owner accepts it).
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : request/response bus, slave side (see alu_share_arbiter_if)
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  localparam int IDW = $clog2(NREQ);

  state_t            state;
  state_t            state_nx;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [2:0]        op_m;
  logic [WIDTH-1:0]  rsp_y;
  logic              rsp_zf;
  logic              rsp_cf;
  logic              rsp_of;

  logic [NREQ-1:0]   pick_grant;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic [WIDTH-1:0]  alu_y;
  logic              alu_zf;
  logic              alu_cf;
  logic              alu_of;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_accept;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a  (op_a),
    .b  (op_b),
    .m  (op_m),
    .y  (alu_y),
    .zf (alu_zf),
    .cf (alu_cf),
    .of (alu_of)
  );

  // Only the owner's rsp_ready matters; other bits are ignored.
  assign rsp_accept = bus.rsp_ready[grant_id];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          state_nx  = S_EXEC;
        end
      end
      S_EXEC: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (rsp_accept) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_m     <= '0;
      rsp_y    <= '0;
      rsp_zf   <= 1'b0;
      rsp_cf   <= 1'b0;
      rsp_of   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order in this block.
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            op_a     <= bus.req_a[pick_idx*WIDTH +: WIDTH];
            op_b     <= bus.req_b[pick_idx*WIDTH +: WIDTH];
            op_m     <= bus.req_m[pick_idx*3 +: 3];
            grant_id <= pick_idx;
          end
        end
        S_EXEC: begin
          rsp_y  <= alu_y;
          rsp_zf <= alu_zf;
          rsp_cf <= alu_cf;
          rsp_of <= alu_of;
        end
        S_RESP: begin
          // Priority moves past the requester just served, which bounds
          // any continuous requester's wait to NREQ-1 grants.
          if (rsp_accept) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_zf    = rsp_zf;
  assign bus.rsp_cf    = rsp_cf;
  assign bus.rsp_of    = rsp_of;
  assign bus.busy      = (state != S_IDLE);
  assign bus.grant_id  = grant_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter (WIDTH=4, NREQ=4).
// The driver keeps a per-requester pending table and a plain round-robin
// pointer; on each accept it pushes the expected response (computed with
// integer arithmetic) into a queue. A separate monitor pops and compares
// whenever the DUT presents a response.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [3:0] y;
    logic       zf;
    logic       cf;
    logic       of;
    int         acc_cyc;
    bit         seen;
  } exp_t;

  exp_t       sb_q[$];
  int         grant_log[$];
  int         acc_log[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  bit         pend[NREQ];
  logic [3:0] ra[NREQ];
  logic [3:0] rb[NREQ];
  logic [2:0] rm[NREQ];
  int         model_ptr = 0;
  bit         outstanding = 1'b0;
  bit         rand_rsp = 1'b0;
  logic [3:0] rsp_mask = 4'b1111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic definition of each op.
  function automatic logic [6:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] m);
    int ua, ub, sa, sb, r, s;
    logic [3:0] y;
    logic cf, of;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    cf = 1'b0;
    of = 1'b0;
    case (m)
      OP_ADD: begin
        r = ua + ub; s = sa + sb;
        y = 4'(r % 16); cf = (r > 15); of = (s > 7) || (s < -8);
      end
      OP_SUB: begin
        r = ua - ub; s = sa - sb;
        y = 4'((r + 16) % 16); cf = (ua < ub); of = (s > 7) || (s < -8);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = (sa < sb) ? 4'd1 : 4'd0;
      OP_SLTU: y = (ua < ub) ? 4'd1 : 4'd0;
      default: y = ~(a | b);
    endcase
    return {y, (y == 4'd0), cf, of};
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit pend_any();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] m);
    pend[i] = 1'b1;
    ra[i]   = a;
    rb[i]   = b;
    rm[i]   = m;
  endtask

  task automatic post_rand(input int i);
    post(i, 4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  // One cycle: drive at negedge, check the accept decision 1 ns later.
  task automatic step();
    int w;
    logic [6:0] r;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = pend[i];
      bus.req_a[i*4 +: 4]    = ra[i];
      bus.req_b[i*4 +: 4]    = rb[i];
      bus.req_m[i*3 +: 3]    = rm[i];
    end
    bus.rsp_ready = rand_rsp ? 4'($urandom) : rsp_mask;
    #1;
    w = outstanding ? -1 : pick();
    check("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
    if (w >= 0) begin
      check("busy_at_accept", 32'(bus.busy), 32'd0);
      r = ref_alu(ra[w], rb[w], rm[w]);
      sb_q.push_back('{id: w, y: r[6:3], zf: r[2], cf: r[1], of: r[0], acc_cyc: cyc, seen: 1'b0});
      grant_log.push_back(w);
      acc_log.push_back(cyc);
      pend[w]     = 1'b0;
      model_ptr   = (w + 1) % NREQ;
      outstanding = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((outstanding || pend_any()) && n < 80) begin
      step();
      n++;
    end
    if (outstanding || pend_any()) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_y",     32'(bus.rsp_y), 32'd0);
    check("rst_flags",     32'({bus.rsp_zf, bus.rsp_cf, bus.rsp_of}), 32'd0);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_grant_id",  32'(bus.grant_id), 32'd0);
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with no request outstanding", bus.rsp_valid);
      end else begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1 << sb_q[0].id));
        check("rsp_y", 32'(bus.rsp_y), 32'(sb_q[0].y));
        if (!sb_q[0].seen) begin
          sb_q[0].seen = 1'b1;
          check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd2);
          check("busy_in_resp", 32'(bus.busy), 32'd1);
          check("grant_id", 32'(bus.grant_id), 32'(sb_q[0].id));
        end
        if (bus.rsp_ready[sb_q[0].id]) begin
          check("rsp_flags", 32'({bus.rsp_zf, bus.rsp_cf, bus.rsp_of}),
                32'({sb_q[0].zf, sb_q[0].cf, sb_q[0].of}));
          void'(sb_q.pop_front());
          outstanding = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; ra[i] = '0; rb[i] = '0; rm[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_m     = '0;
    bus.rsp_ready = '0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed: add, zero-result sub, plain sub.
    post(0, 4'd3, 4'd5, OP_ADD);
    wait_idle("add");
    post(2, 4'd5, 4'd5, OP_SUB);
    wait_idle("sub_zero");
    post(2, 4'd7, 4'd1, OP_SUB);
    wait_idle("sub");

    // All four requesting continuously: strict rotation, one accept per 3 cycles.
    grant_log.delete();
    acc_log.delete();
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) post_rand(i);
      step();
    end
    wait_idle("rotation");
    check("rotation_grants", 32'(grant_log.size() >= 5), 32'd1);
    for (int j = 1; j < grant_log.size(); j++) begin
      check("rotation_order", 32'(grant_log[j]), 32'((grant_log[j-1] + 1) % NREQ));
      if (j < 5) check("accept_spacing", 32'(acc_log[j] - acc_log[j-1]), 32'd3);
    end

    // After a grant to 1, requesters 3 and 0: 3 comes first.
    post(1, 4'd2, 4'd9, OP_XOR);
    wait_idle("grant1");
    grant_log.delete();
    post(0, 4'd8, 4'd8, OP_ADD);
    post(3, 4'd4, 4'd9, OP_SLT);
    wait_idle("pair");
    check("pair_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("pair_first", 32'(grant_log[0]), 32'd3);
      check("pair_second", 32'(grant_log[1]), 32'd0);
    end

    // Response held back: result stays put, nobody else is accepted.
    rsp_mask = 4'b0000;
    post(1, 4'd9, 4'd9, OP_ADD);
    step();
    post(2, 4'd1, 4'd2, OP_SUB);
    for (int n = 0; n < 7; n++) step();
    check("hold_queue", 32'(sb_q.size()), 32'd1);
    rsp_mask = 4'b1111;
    wait_idle("hold_release");

    // Reset in EXEC with rr_ptr at 1: discard, then 0 wins 0011.
    post(0, 4'd1, 4'd1, OP_AND);
    wait_idle("pre_reset");
    post(1, 4'd6, 4'd3, OP_ADD);
    step();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check_reset_outputs();
    sb_q.delete();
    outstanding = 1'b0;
    model_ptr   = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    post(0, 4'd2, 4'd3, OP_ADD);
    post(1, 4'd5, 4'd7, OP_SUB);
    wait_idle("after_reset");
    check("rr_after_reset_cnt", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("rr_after_reset_first", 32'(grant_log[0]), 32'd0);

    // Random traffic with random rsp_ready and occasional withdrawals.
    rand_rsp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) post_rand(i);
        else if (pend[i] && ($urandom % 25 == 0)) pend[i] = 1'b0;
      end
      step();
    end
    rand_rsp = 1'b0;
    rsp_mask = 4'b1111;
    wait_idle("random");
    step();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
